// File: rtl/morse_sched_pkg.sv
// -----------------------------------------------------------------------------
// morse_sched_pkg
// Shared constants and types for the Morse character scheduler.
//   - PS/2 scan-code prefixes (break / extended) and the default backspace code.
//   - FSM state encoding used by morse_char_scheduler.
//   - Filter-to-FIFO request record.
//   - level_width(): width of a 0..DEPTH occupancy counter.
// -----------------------------------------------------------------------------
package morse_sched_pkg;

    localparam logic [7:0] SC_BREAK             = 8'hF0;
    localparam logic [7:0] SC_EXT               = 8'hE0;
    localparam logic [7:0] SC_BACKSPACE_DEFAULT = 8'h66;

    // Issue FSM states
    typedef logic [2:0] sched_state_t;
    localparam sched_state_t ST_IDLE      = 3'd0;
    localparam sched_state_t ST_ISSUE     = 3'd1;
    localparam sched_state_t ST_WAIT_BUSY = 3'd2;
    localparam sched_state_t ST_WAIT_DONE = 3'd3;
    localparam sched_state_t ST_GAP       = 3'd4;

    // One filtered scan code, registered before it reaches the queue
    typedef struct packed {
        logic       push;   // enqueue data
        logic       drop;   // delete newest entry (backspace)
        logic [7:0] data;
    } filt_req_t;

    // Occupancy counters must represent 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/morse_char_scheduler_if.sv
// -----------------------------------------------------------------------------
// morse_char_scheduler_if
// Bundles the PS/2 byte stream, the encoder handshake and the queue status of
// morse_char_scheduler.
//   master : the scheduler side (consumes PS/2 bytes and enc_busy,
//            drives enc_data/enc_strb and the status flags)
//   slave  : the surrounding system (PS/2 controller, encoder, monitors)
// Signals:
//   ps2_received_data[7:0], ps2_received_data_strb  - byte stream from PS/2
//   enc_busy                                        - encoder is emitting
//   enc_data[7:0], enc_strb                         - character issue
//   fifo_level, fifo_empty, overflow                - queue status
// -----------------------------------------------------------------------------
interface morse_char_scheduler_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         ps2_received_data;
    logic               ps2_received_data_strb;
    logic               enc_busy;
    logic [7:0]         enc_data;
    logic               enc_strb;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_empty;
    logic               overflow;

    modport master (
        input  ps2_received_data,
        input  ps2_received_data_strb,
        input  enc_busy,
        output enc_data,
        output enc_strb,
        output fifo_level,
        output fifo_empty,
        output overflow
    );

    modport slave (
        output ps2_received_data,
        output ps2_received_data_strb,
        output enc_busy,
        input  enc_data,
        input  enc_strb,
        input  fifo_level,
        input  fifo_empty,
        input  overflow
    );

endinterface

// File: rtl/morse_sched_fifo.sv
// -----------------------------------------------------------------------------
// morse_sched_fifo
// Small synchronous FIFO with an extra "drop_newest" operation that un-writes
// the most recent entry (used for backspace).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   push, push_data     - enqueue (accepted when not full, or when a pop
//                         frees a slot in the same cycle)
//   pop                 - dequeue head (ignored when empty)
//   drop_newest         - delete the newest entry remaining after any pop
//   rd_data             - current head entry
//   level, full, empty  - occupancy
// -----------------------------------------------------------------------------
module morse_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             drop_newest,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [LW-1:0]    level_reg, level_next;
    logic             do_push, do_pop, do_drop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LVL_MAX);
    assign level   = level_reg;
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        // The pop is applied first; the drop only touches what is left, so a
        // lone entry that is being popped cannot also be deleted.
        do_drop = drop_newest && !do_push &&
                  (do_pop ? (level_reg > LVL_ONE) : !empty);

        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        level_next  = level_reg;
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
            level_next  = level_next - LVL_ONE;
        end
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            level_next  = level_next + LVL_ONE;
        end
        if (do_drop) begin
            wr_ptr_next = wr_ptr_reg - PTR_ONE;
            level_next  = level_next - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/morse_char_scheduler.sv
// -----------------------------------------------------------------------------
// morse_char_scheduler
// Filters raw PS/2 scan-code bytes, queues accepted make codes and issues them
// one at a time to a Morse encoder, honouring the encoder's busy flag and a
// programmable inter-character gap.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - morse_char_scheduler_if.master (PS/2 bytes in, encoder handshake,
//            fifo_level / fifo_empty / overflow status out)
// Parameters: FIFO_DEPTH (power of two, >= 2), GAP_CYCLES, BUSY_TIMEOUT,
//             BACKSPACE_CODE.
// Optional build macro: MORSE_SCHED_TYPEMATIC_FILTER_EN - suppresses keyboard
// auto-repeat by discarding a make equal to the last accepted make until that
// key's break code is seen.
// -----------------------------------------------------------------------------
module morse_char_scheduler
    import morse_sched_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 8,
    parameter int         GAP_CYCLES     = 16,
    parameter int         BUSY_TIMEOUT   = 16,
    parameter logic [7:0] BACKSPACE_CODE = SC_BACKSPACE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    morse_char_scheduler_if.master bus
);
    localparam int LW      = level_width(FIFO_DEPTH);
    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    // GAP_CYCLES=0 still spends one cycle in GAP, same as GAP_CYCLES=1.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // ---------------------------------------------------------------- filter
    logic      skip_reg, skip_next;
    filt_req_t req_reg, req_next;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
    logic       brk_reg, brk_next;          // pending skip came from F0
    logic [7:0] last_make_reg, last_make_next;
    logic       last_vld_reg, last_vld_next;
`endif

    always_comb begin
        skip_next = skip_reg;
        req_next  = '0;
        req_next.data = bus.ps2_received_data;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
        brk_next       = brk_reg;
        last_make_next = last_make_reg;
        last_vld_next  = last_vld_reg;
`endif
        if (bus.ps2_received_data_strb) begin
            if (skip_reg) begin
                // Second byte of a break/extended sequence is swallowed.
                skip_next = 1'b0;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
                if (brk_reg && last_vld_reg && (bus.ps2_received_data == last_make_reg)) begin
                    last_vld_next = 1'b0;   // key released: next press counts
                end
`endif
            end else if (bus.ps2_received_data == SC_BREAK) begin
                skip_next = 1'b1;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
                brk_next  = 1'b1;
`endif
            end else if (bus.ps2_received_data == SC_EXT) begin
                skip_next = 1'b1;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
                brk_next  = 1'b0;
            end else if (last_vld_reg && (bus.ps2_received_data == last_make_reg)) begin
                // Auto-repeat of the held key: discard.
                skip_next = 1'b0;
`endif
            end else begin
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
                last_make_next = bus.ps2_received_data;
                last_vld_next  = 1'b1;
`endif
                if (bus.ps2_received_data == BACKSPACE_CODE) begin
                    req_next.drop = 1'b1;
                end else begin
                    req_next.push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_reg <= 1'b0;
            req_reg  <= '0;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
            brk_reg       <= 1'b0;
            last_make_reg <= '0;
            last_vld_reg  <= 1'b0;
`endif
        end else begin
            skip_reg <= skip_next;
            req_reg  <= req_next;
`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
            brk_reg       <= brk_next;
            last_make_reg <= last_make_next;
            last_vld_reg  <= last_vld_next;
`endif
        end
    end

    // ------------------------------------------------------------------ queue
    logic          pop;
    logic [7:0]    head_data;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;
    logic          overflow_reg, overflow_next;

    morse_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (req_reg.push),
        .push_data   (req_reg.data),
        .pop         (pop),
        .drop_newest (req_reg.drop),
        .rd_data     (head_data),
        .level       (fifo_level),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // A push is lost only when the queue is full and no pop frees a slot.
    always_comb begin
        overflow_next = overflow_reg;
        if (req_reg.push && fifo_full && !pop) begin
            overflow_next = 1'b1;
        end else if (fifo_empty) begin
            overflow_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------- FSM
    sched_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       enc_data_reg, enc_data_next;
    logic             enc_strb_reg, enc_strb_next;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        enc_data_next = enc_data_reg;
        enc_strb_next = 1'b0;
        pop           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && !bus.enc_busy) begin
                    pop           = 1'b1;
                    enc_data_next = head_data;
                    enc_strb_next = 1'b1;       // high for the ISSUE cycle only
                    state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // An encoder that never acknowledges must not stall the queue.
                if (bus.enc_busy || (cnt_reg == BUSY_LAST)) begin
                    state_next = ST_WAIT_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.enc_busy) begin
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            enc_data_reg <= '0;
            enc_strb_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            enc_data_reg <= enc_data_next;
            enc_strb_reg <= enc_strb_next;
            overflow_reg <= overflow_next;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.enc_data   = enc_data_reg;
    assign bus.enc_strb   = enc_strb_reg;
    assign bus.fifo_level = fifo_level;
    assign bus.fifo_empty = fifo_empty;
    assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_morse_char_scheduler.sv
// -----------------------------------------------------------------------------
// tb_morse_char_scheduler
// Directed bench for morse_char_scheduler with default parameters
// (FIFO_DEPTH=8, GAP_CYCLES=16, BUSY_TIMEOUT=16, BACKSPACE_CODE=8'h66).
// A small encoder model answers enc_strb with a 4-cycle busy pulse, can hold
// busy high, or can stay silent to exercise the acknowledge timeout.
// Honours MORSE_SCHED_TYPEMATIC_FILTER_EN for the auto-repeat expectation.
// -----------------------------------------------------------------------------
module tb_morse_char_scheduler;

`ifdef MORSE_SCHED_TYPEMATIC_FILTER_EN
    localparam int REP_EXP = 2;
`else
    localparam int REP_EXP = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    morse_char_scheduler_if #(.FIFO_DEPTH(8)) bus ();

    morse_char_scheduler #(
        .FIFO_DEPTH     (8),
        .GAP_CYCLES     (16),
        .BUSY_TIMEOUT   (16),
        .BACKSPACE_CODE (8'h66)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] issued_q[$];
    int         stamp_q[$];
    bit         hold_busy = 1'b0;
    bit         respond   = 1'b1;
    int         busy_left = 0;
    int         send_cyc  = 0;

    logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                              8'h35, 8'h3C, 8'h43, 8'h44};

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Encoder model and issue monitor, both away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_left    = 0;
            bus.enc_busy = 1'b0;
        end else begin
            if (bus.enc_strb) begin
                issued_q.push_back(bus.enc_data);
                stamp_q.push_back(cyc);
                $display("issue data=0x%02h cyc=%0d", bus.enc_data, cyc);
                if (respond) busy_left = 4;
            end
            if (hold_busy) begin
                bus.enc_busy = 1'b1;
            end else if (busy_left > 0) begin
                bus.enc_busy = 1'b1;
                busy_left--;
            end else begin
                bus.enc_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.ps2_received_data      = b;
        bus.ps2_received_data_strb = 1'b1;
        send_cyc = cyc;
        @(negedge clk);
        bus.ps2_received_data_strb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.ps2_received_data      = 8'h00;
        bus.ps2_received_data_strb = 1'b0;
        hold_busy = 1'b0;
        respond   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issued_q.delete();
        stamp_q.delete();
    endtask

    initial begin
        int t0;
        int n_bad;
        bus.enc_busy = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("rst_enc_strb",   int'(bus.enc_strb),   0);
        check_eq("rst_enc_data",   int'(bus.enc_data),   0);
        check_eq("rst_fifo_level", int'(bus.fifo_level), 0);
        check_eq("rst_fifo_empty", int'(bus.fifo_empty), 1);
        check_eq("rst_overflow",   int'(bus.overflow),   0);

        // 1C, F0 1C: one issue, 3 cycles after the first strb
        send(8'h1C);
        t0 = send_cyc;
        send(8'hF0);
        send(8'h1C);
        repeat (60) @(negedge clk);
        check_eq("brk_count",   issued_q.size(), 1);
        check_eq("brk_data",    (issued_q.size() > 0) ? int'(issued_q[0]) : -1, 'h1C);
        check_eq("brk_latency", (stamp_q.size() > 0) ? stamp_q[0] - t0 : -1, 3);
        check_eq("brk_level",   int'(bus.fifo_level), 0);

        // E0 75 dropped, 32 issued
        do_reset();
        send(8'hE0);
        send(8'h75);
        send(8'h32);
        repeat (60) @(negedge clk);
        check_eq("ext_count", issued_q.size(), 1);
        check_eq("ext_data",  (issued_q.size() > 0) ? int'(issued_q[0]) : -1, 'h32);

        // Nine makes with busy held: full queue, overflow, ninth lost
        do_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) send(codes[i]);
        repeat (3) @(negedge clk);
        check_eq("ovf_level",    int'(bus.fifo_level), 8);
        check_eq("ovf_flag",     int'(bus.overflow),   1);
        check_eq("ovf_no_issue", issued_q.size(),      0);
        hold_busy = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("ovf_drain_count", issued_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("ovf_order%0d", i),
                     (i < issued_q.size()) ? int'(issued_q[i]) : -1, int'(codes[i]));
        end
        n_bad = 0;
        foreach (issued_q[i]) if (issued_q[i] == codes[8]) n_bad++;
        check_eq("ovf_ninth_absent", n_bad, 0);
        check_eq("ovf_cleared",      int'(bus.overflow),   0);
        check_eq("ovf_drain_level",  int'(bus.fifo_level), 0);

        // Backspace deletes newest; backspace on empty queue is ignored
        do_reset();
        hold_busy = 1'b1;
        send(8'h1C);
        send(8'h32);
        send(8'h66);
        repeat (3) @(negedge clk);
        check_eq("bs_level", int'(bus.fifo_level), 1);
        hold_busy = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("bs_count", issued_q.size(), 1);
        check_eq("bs_data",  (issued_q.size() > 0) ? int'(issued_q[0]) : -1, 'h1C);
        send(8'h66);
        repeat (3) @(negedge clk);
        check_eq("bs_empty_level", int'(bus.fifo_level), 0);
        check_eq("bs_empty_count", issued_q.size(),      1);

        // Silent encoder: strb-to-strb = 1 + 16 + 1 + 16 + 1 = 35 cycles
        do_reset();
        respond = 1'b0;
        send(8'h1C);
        send(8'h32);
        repeat (100) @(negedge clk);
        check_eq("tmo_count",   issued_q.size(), 2);
        check_eq("tmo_spacing", (stamp_q.size() > 1) ? stamp_q[1] - stamp_q[0] : -1, 35);

        // Auto-repeat stream
        do_reset();
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'h1C);
        repeat (150) @(negedge clk);
        check_eq("rep_count", issued_q.size(), REP_EXP);
        n_bad = 0;
        foreach (issued_q[i]) if (issued_q[i] != 8'h1C) n_bad++;
        check_eq("rep_data", n_bad, 0);

        // Asynchronous reset mid-queue drops everything immediately
        do_reset();
        hold_busy = 1'b1;
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        repeat (3) @(negedge clk);
        check_eq("arst_pre_level", int'(bus.fifo_level), 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_level", int'(bus.fifo_level), 0);
        check_eq("arst_empty", int'(bus.fifo_empty), 1);
        check_eq("arst_strb",  int'(bus.enc_strb),   0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_char_scheduler.md
Name: morse_char_scheduler

Overview:
Sits between ps2_controller and morse_code_encoder.
- Filters raw PS/2 scan-code bytes: drops break sequences (F0 xx), drops extended sequences (E0 xx), and handles backspace.
- Queues accepted make codes in a small FIFO.
- Issues them to the encoder one at a time. Each issue waits for the encoder to finish and for a programmable inter-character gap to expire.

Parameters:
- FIFO_DEPTH, 8, queue entries; power of two, at least 2.
- GAP_CYCLES, 16, idle clk cycles inserted after the encoder drops busy, before the next issue; 0 allowed.
- BUSY_TIMEOUT, 16, cycles to wait for enc_busy to rise after enc_strb before treating the character as consumed.
- BACKSPACE_CODE, 8'h66, make code that deletes the newest queued entry.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ps2_received_data, input, 8, byte from ps2_controller.
- ps2_received_data_strb, input, 1, one-cycle valid pulse for ps2_received_data.
- enc_busy, input, 1, high while the encoder is emitting a character.
- enc_data, output, 8, make code presented to the encoder.
- enc_strb, output, 1, one-cycle pulse; enc_data is valid in this cycle.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, number of queued entries.
- fifo_empty, output, 1, fifo_level==0.
- overflow, output, 1, sticky flag: a make code was dropped because the queue was full.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except fifo_empty=1. FIFO is cleared, prefix flags are cleared, FSM enters IDLE.
- Byte filter (runs only on strb cycles):
  - 8'hF0 sets skip_next.
  - 8'hE0 sets skip_next.
  - Any byte arriving while skip_next=1 is discarded and clears skip_next.
  - A BACKSPACE_CODE byte removes the newest entry; ignored if the queue is empty.
  - Every other byte is pushed.
- FIFO write timing: a push or delete takes effect in the cycle after the strb. The byte is visible in fifo_level one cycle after the strb.
- Full queue: a push is dropped and overflow is set. overflow clears only on reset or when the queue drains to empty.
- FSM states:
  - IDLE: if the queue is non-empty and enc_busy=0, pop the oldest entry, load enc_data, go to ISSUE.
  - ISSUE: drive enc_strb=1 for exactly one cycle, clear the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when enc_busy=1, or when the counter reaches BUSY_TIMEOUT-1.
  - WAIT_DONE: go to GAP when enc_busy=0.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, GAP lasts 1 cycle.
- Minimum latency: from strb of a make code into an empty, idle block, enc_strb is asserted 3 cycles later (strb N, write N+1, pop N+2, strb N+3).
- enc_data holds its value until the next pop.
- Simultaneous pop and push: both occur and fifo_level is unchanged.
- Simultaneous pop and backspace:
  - The pop is performed first.
  - The backspace then deletes the newest remaining entry, if one exists.
  - With level 1, the backspace is ignored.
- enc_busy already high in IDLE: no issue until it falls.
- Asserting rst_n mid-character aborts immediately: enc_strb=0 and the queue is lost.

Optional Feature:
Macro: MORSE_SCHED_TYPEMATIC_FILTER_EN.
- Defined:
  - Store last_make, the most recently accepted make code.
  - A make equal to last_make is discarded (keyboard auto-repeat).
  - The break of last_make (F0 followed by that code) clears last_make.
  - BACKSPACE_CODE is also subject to this filter.
- Not defined: every make code is queued, so auto-repeat produces repeated characters.

Decomposition:
- Package morse_sched_pkg:
  - Scan-code constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_BACKSPACE_DEFAULT=8'h66.
  - FSM state typedef: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- Sub-module morse_sched_fifo: synchronous FIFO with push, pop and drop_newest ports, plus level/full/empty outputs.
- The top of this block holds the byte filter and the FSM.

Test Plan:
- Bytes 1C, F0, 1C into an idle block with enc_busy=0 → exactly one enc_strb with enc_data=1C, 3 cycles after the first strb. Final fifo_level=0.
- Bytes E0, 75, 32 → only 32 is issued; 75 is never issued.
- Nine makes (FIFO_DEPTH=8) with enc_busy held 1 → fifo_level=8, overflow=1. The ninth code is absent from the output. overflow clears after the queue drains.
- Queue 1C, 32, 66 with enc_busy=1 → fifo_level=1 and only 1C is issued. A backspace on an empty queue leaves fifo_level=0.
- enc_busy never rises after enc_strb → FSM leaves WAIT_BUSY after 16 cycles. The next enc_strb occurs 16+GAP_CYCLES+2 cycles after that.
- With MORSE_SCHED_TYPEMATIC_FILTER_EN: bytes 1C, 1C, 1C, F0, 1C, 1C → enc_data=1C issued twice. Without the macro → issued 4 times.
